// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point datapath arbiter: ALU op codes,
// FSM state type, data width and the result returned on a timeout.
package fpu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = '0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 (with wrap)
// and grants the first active request as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               any_o
);

    logic [IdxW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IdxW'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one floating-point datapath among NUM_REQ requesters with round-robin
// arbitration. Optional WAIT-state timeout is enabled by FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_error,
    output logic                      dp_start,
    output logic [1:0]                dp_alu_control,
    output logic [DATA_W-1:0]         dp_a,
    output logic [DATA_W-1:0]         dp_b,
    input  logic [DATA_W-1:0]         dp_result,
    input  logic                      dp_done
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ReqOne = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gen_param_check
        $error("fpu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    arb_state_e          state_q;
    logic [IdxW-1:0]     owner_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic                dp_start_q;
    logic [1:0]          dp_op_q;
    logic [DATA_W-1:0]   dp_a_q;
    logic [DATA_W-1:0]   dp_b_q;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0]   resp_result_q;
    logic                resp_error_q;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0] tmo_cnt_q;
`endif

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_any;

    logic [1:0]        op_arr [NUM_REQ];
    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
        assign op_arr[g] = req_op[2*g +: 2];
        assign a_arr[g]  = req_a[DATA_W*g +: DATA_W];
        assign b_arr[g]  = req_b[DATA_W*g +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Grants are only visible while idle; acceptance happens on the same edge.
    assign req_ready = (state_q == StIdle) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= '0;
            rr_ptr_q      <= IdxW'(NUM_REQ - 1);
            dp_start_q    <= 1'b0;
            dp_op_q       <= '0;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_error_q  <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        dp_op_q    <= op_arr[gnt_idx];
                        dp_a_q     <= a_arr[gnt_idx];
                        dp_b_q     <= b_arr[gnt_idx];
                        owner_q    <= gnt_idx;
                        dp_start_q <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    dp_start_q <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
                    tmo_cnt_q  <= '0;
`endif
                    state_q    <= StWait;
                end
                StWait: begin
                    // A done on the limit cycle still returns the real result.
                    if (dp_done) begin
                        resp_result_q <= dp_result;
                        resp_error_q  <= 1'b0;
                        resp_valid_q  <= ReqOne << owner_q;
                        state_q       <= StResp;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        resp_result_q <= TIMEOUT_RESULT;
                        resp_error_q  <= 1'b1;
                        resp_valid_q  <= ReqOne << owner_q;
                        state_q       <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        rr_ptr_q     <= owner_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dp_start       = dp_start_q;
    assign dp_alu_control = dp_op_q;
    assign dp_a           = dp_a_q;
    assign dp_b           = dp_b_q;
    assign resp_valid     = resp_valid_q;
    assign resp_result    = resp_result_q;
    assign resp_error     = resp_error_q;

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one floating-point datapath (start/done, 2-bit ALU_Control, 32-bit a/b, 32-bit result) among NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready request handshake and a held response per requester.
- Sequences the datapath: operands held stable, one-cycle start pulse, waits for done, captures the result, returns it to the owning requester.
- Sits between client engines and the datapath. It is the only driver of the datapath's start, ALU_Control, a and b.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_op  input  2*NUM_REQ  ALU_Control per requester; slice i = [2i+1:2i]
- req_a  input  32*NUM_REQ  operand a per requester; slice i = [32i+31:32i]
- req_b  input  32*NUM_REQ  operand b per requester
- resp_valid  output  NUM_REQ  result valid, one-hot or zero
- resp_ready  input  NUM_REQ  per-requester response accept
- resp_result  output  32  result for the owner of resp_valid
- resp_error  output  1  timeout flag, qualified by resp_valid
- dp_start  output  1  start pulse to the datapath
- dp_alu_control  output  2  to datapath ALU_Control
- dp_a  output  32  to datapath a
- dp_b  output  32  to datapath b
- dp_result  input  32  datapath result_out
- dp_done  input  1  datapath done

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-operation):
  - state=IDLE; owner=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - All registered outputs 0: dp_start, dp_alu_control, dp_a, dp_b, resp_valid, resp_result, resp_error.
  - An in-flight operation is abandoned. A later dp_done for it is ignored.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[winner]=1 combinationally, in IDLE only. req_ready is 0 in all other states.
  - On acceptance, register the winner's op/a/b into dp_alu_control/dp_a/dp_b, set owner=winner, go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE: dp_start=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - dp_start=0. dp_a/dp_b/dp_alu_control stay stable until the state leaves RESP.
  - On the first cycle with dp_done=1: capture dp_result into resp_result, resp_error=0, go to RESP.
  - dp_done is level-sampled in WAIT only and ignored in every other state.
- RESP:
  - resp_valid[owner]=1; resp_result and resp_error held stable.
  - When resp_ready[owner]=1: clear resp_valid, set rr_ptr=owner, go to IDLE.
  - resp_ready of non-owners is ignored.
- Timing:
  - Minimum request-to-response latency = 3 cycles + datapath done latency.
  - Back-to-back issue requires one IDLE cycle between operations; there is no pipelining.
- Simultaneous requests: only the winner sees req_ready. Losers must hold req_valid and payload stable, and are served in rotating order.
- A requester dropping req_valid before acceptance loses its slot; this is not an error.
- Width rules: all data is passed through unmodified. There is no arithmetic on operands.

Optional Feature:
- Macro FPU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with dp_done still 0: resp_result=32'h0, resp_error=1, go to RESP.
  - If dp_done arrives on the same cycle the limit is reached, dp_done wins (normal result, resp_error=0).
- Undefined: no counter; WAIT waits indefinitely; resp_error is tied 0.

Decomposition:
- Shared package fpu_pkg:
  - ALU op encodings (2-bit ALU_Control localparams).
  - FSM state typedef: IDLE/ISSUE/WAIT/RESP.
  - Data width constant DATA_W=32.
  - Timeout result constant.
- One natural sub-module: rr_arbiter (NUM_REQ request vector plus rr_ptr in, one-hot grant out, purely combinational), reusable elsewhere.

Test Plan:
- Single request: requester 0 issues op=2'b00, a=32'h3FC00000, b=32'h40200000. Expect req_ready[0] in the cycle after IDLE, dp_start high for exactly 1 cycle, dp_a/dp_b stable until the response, resp_valid[0] with resp_result equal to dp_result.
- Contention: requesters 0–3 all valid from reset. Expect grants in order 0,1,2,3,0. Requester 2 re-asserted after its service is next served only after 3 and 0.
- Response backpressure: resp_ready[1] held low for 10 cycles. Expect resp_valid[1] and resp_result held constant and no new req_ready in that time; acceptance one cycle after resp_ready[1]=1.
- Reset mid-operation: rst pulsed in WAIT, then a late dp_done arrives. Expect all outputs 0, no resp_valid, and the next grant goes to requester 0.
- Stray done: dp_done pulsed in IDLE and in RESP. Expect no state change and no result overwrite.
- Timeout (FPU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): dp_done never asserted. Expect resp_valid[owner] with resp_error=1 and resp_result=0. Repeat with dp_done on the limit cycle: expect resp_error=0 and the real result.
